// File: rtl/ps2_voice_allocator.sv
// PS/2 set-2 voice allocator.
// Decodes make/break/extended prefixes from received scan bytes and maps
// held keys onto a fixed pool of note voices. A new note takes the
// lowest-index free voice. When the pool is full it either steals the
// oldest voice or drops the note.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | no prefix pending; 01..7F is a make
// S_BRK     | F0 seen; 01..7F is a break
// S_EXT     | E0 seen; extended key, never produces events
// S_EXT_BRK | E0 F0 seen; next byte swallowed
module ps2_voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 3,
   parameter int STEAL_EN   = 1
) (
   input  logic                    iCLK_50,
   input  logic                    reset,
   input  logic                    scan_valid,
   input  logic [7:0]              scan_code,
   input  logic                    all_off,
   output logic [NUM_VOICES-1:0]   voice_on,
   output logic [8*NUM_VOICES-1:0] voice_code,
   output logic [NUM_VOICES-1:0]   voice_trig,
   output logic                    steal_pulse,
   output logic                    drop_pulse
);

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} pfx_t;

   localparam logic [AGE_W-1:0] AGE_MAX   = '1;
   localparam logic [7:0]       CODE_FREE = 8'hF0;

   pfx_t                  pfx_q, pfx_d;
   logic                  make_ev, brk_ev, is_key;

   logic [NUM_VOICES-1:0] on_q, on_d;
   logic [7:0]            code_q [NUM_VOICES];
   logic [7:0]            code_d [NUM_VOICES];
   logic [AGE_W-1:0]      age_q  [NUM_VOICES];
   logic [AGE_W-1:0]      age_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] trig_q, trig_d;
   logic                  steal_q, steal_d;
   logic                  drop_q, drop_d;

   logic                  hit, free_any, old_found, alloc;
   int                    hit_idx, free_idx, old_idx, alloc_idx;
   logic [AGE_W-1:0]      old_age;

   assign is_key = (scan_code != 8'h00) && !scan_code[7];

   // Prefix decoder: next prefix state and the make/break event of this byte.
   always_comb begin
      pfx_d   = pfx_q;
      make_ev = 1'b0;
      brk_ev  = 1'b0;
      if (scan_valid && !all_off) begin
         case (pfx_q)
            S_IDLE: begin
               if (scan_code == 8'hF0)      pfx_d = S_BRK;
               else if (scan_code == 8'hE0) pfx_d = S_EXT;
               else if (is_key)             make_ev = 1'b1;
            end
            S_BRK: begin
               if (is_key) begin
                  brk_ev = 1'b1;
                  pfx_d  = S_IDLE;
               end
               else if (scan_code == 8'hF0) pfx_d = S_BRK;
               else if (scan_code == 8'hE0) pfx_d = S_EXT;
               else                         pfx_d = S_IDLE;
            end
            S_EXT: begin
               if (scan_code == 8'hF0) pfx_d = S_EXT_BRK;
               else                    pfx_d = S_IDLE;
            end
            default: pfx_d = S_IDLE;
         endcase
      end
      if (all_off) pfx_d = S_IDLE;
   end

   // Voice search: held match, lowest free slot, oldest active slot.
   always_comb begin
      hit       = 1'b0;
      hit_idx   = 0;
      free_any  = 1'b0;
      free_idx  = 0;
      old_found = 1'b0;
      old_idx   = 0;
      old_age   = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (on_q[i] && code_q[i] == scan_code && !hit) begin
            hit     = 1'b1;
            hit_idx = i;
         end
         if (!on_q[i] && !free_any) begin
            free_any = 1'b1;
            free_idx = i;
         end
         // strict compare keeps the lowest index on equal ages
         if (on_q[i] && (!old_found || age_q[i] > old_age)) begin
            old_found = 1'b1;
            old_idx   = i;
            old_age   = age_q[i];
         end
      end
   end

   // Voice table update for make/break events and panic clear.
   always_comb begin
      on_d      = on_q;
      code_d    = code_q;
      age_d     = age_q;
      trig_d    = '0;
      steal_d   = 1'b0;
      drop_d    = 1'b0;
      alloc     = 1'b0;
      alloc_idx = 0;

      if (make_ev && !hit) begin
         if (free_any) begin
            alloc     = 1'b1;
            alloc_idx = free_idx;
         end
         else if (STEAL_EN != 0) begin
            alloc     = 1'b1;
            alloc_idx = old_idx;
            steal_d   = 1'b1;
         end
         else begin
            drop_d = 1'b1;
         end
      end

      if (alloc) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (i == alloc_idx) begin
               on_d[i]   = 1'b1;
               code_d[i] = scan_code;
               age_d[i]  = '0;
               trig_d[i] = 1'b1;
            end
            else if (on_q[i] && age_q[i] != AGE_MAX) begin
               age_d[i] = age_q[i] + 1'b1;
            end
         end
      end

      if (brk_ev && hit) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (i == hit_idx) begin
               on_d[i]   = 1'b0;
               code_d[i] = CODE_FREE;
               age_d[i]  = AGE_MAX;
            end
         end
      end

      if (all_off) begin
         on_d    = '0;
         trig_d  = '0;
         steal_d = 1'b0;
         drop_d  = 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            code_d[i] = CODE_FREE;
            age_d[i]  = AGE_MAX;
         end
      end
   end

   // Prefix state register.
   always_ff @(posedge iCLK_50 or negedge reset) begin
      if (!reset) pfx_q <= S_IDLE;
      else        pfx_q <= pfx_d;
   end

   // Voice table and pulse registers.
   always_ff @(posedge iCLK_50 or negedge reset) begin
      if (!reset) begin
         on_q    <= '0;
         trig_q  <= '0;
         steal_q <= 1'b0;
         drop_q  <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            code_q[i] <= CODE_FREE;
            age_q[i]  <= AGE_MAX;
         end
      end
      else begin
         on_q    <= on_d;
         trig_q  <= trig_d;
         steal_q <= steal_d;
         drop_q  <= drop_d;
         for (int i = 0; i < NUM_VOICES; i++) begin
            code_q[i] <= code_d[i];
            age_q[i]  <= age_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_code
      assign voice_code[8*g +: 8] = code_q[g];
   end

   assign voice_on    = on_q;
   assign voice_trig  = trig_q;
   assign steal_pulse = steal_q;
   assign drop_pulse  = drop_q;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed bench for ps2_voice_allocator: one stealing and one dropping
// instance share the same byte stream.
module tb_ps2_voice_allocator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scan_valid;
   logic [7:0]  scan_code;
   logic        all_off;

   logic [3:0]  s_on, s_trig, d_on, d_trig;
   logic [31:0] s_code, d_code;
   logic        s_steal, s_drop, d_steal, d_drop;

   int n_checks = 0;
   int n_errors = 0;

   always #10 clk = ~clk;

   ps2_voice_allocator #(.NUM_VOICES(4), .AGE_W(3), .STEAL_EN(1)) u_steal (
      .iCLK_50(clk), .reset(rst_n), .scan_valid(scan_valid), .scan_code(scan_code),
      .all_off(all_off), .voice_on(s_on), .voice_code(s_code), .voice_trig(s_trig),
      .steal_pulse(s_steal), .drop_pulse(s_drop));

   ps2_voice_allocator #(.NUM_VOICES(4), .AGE_W(3), .STEAL_EN(0)) u_drop (
      .iCLK_50(clk), .reset(rst_n), .scan_valid(scan_valid), .scan_code(scan_code),
      .all_off(all_off), .voice_on(d_on), .voice_code(d_code), .voice_trig(d_trig),
      .steal_pulse(d_steal), .drop_pulse(d_drop));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] b);
      @(negedge clk);
      scan_valid = 1'b1;
      scan_code  = b;
   endtask

   task automatic idle();
      @(negedge clk);
      scan_valid = 1'b0;
      scan_code  = 8'h00;
   endtask

   task automatic send(input logic [7:0] b);
      drive(b);
      idle();
   endtask

   task automatic chk_s(input string tag, input logic [3:0] on, input logic [31:0] code,
                        input logic [3:0] trig, input logic steal);
      chk({tag, " on"},    {28'd0, s_on},     {28'd0, on});
      chk({tag, " code"},  s_code,            code);
      chk({tag, " trig"},  {28'd0, s_trig},   {28'd0, trig});
      chk({tag, " steal"}, {31'd0, s_steal},  {31'd0, steal});
   endtask

   initial begin
      rst_n      = 1'b0;
      scan_valid = 1'b0;
      scan_code  = 8'h00;
      all_off    = 1'b0;
      repeat (2) @(negedge clk);

      chk_s("reset", 4'b0000, 32'hF0F0F0F0, 4'b0000, 1'b0);
      chk("reset drop", {31'd0, s_drop}, 32'd0);
      rst_n = 1'b1;

      send(8'h1C);
      chk_s("make1C", 4'b0001, 32'hF0F0F01C, 4'b0001, 1'b0);
      idle();
      chk("trig clears", {28'd0, s_trig}, 32'd0);

      send(8'h1C);
      chk_s("typematic", 4'b0001, 32'hF0F0F01C, 4'b0000, 1'b0);

      send(8'h1B);
      send(8'h23);
      send(8'h2B);
      chk_s("fill", 4'b1111, 32'h2B231B1C, 4'b1000, 1'b0);
      chk("fill drop-dut code", d_code, 32'h2B231B1C);

      send(8'h34);
      chk_s("steal34", 4'b1111, 32'h2B231B34, 4'b0001, 1'b1);
      chk("steal34 no drop", {31'd0, s_drop}, 32'd0);
      chk("drop34 pulse", {31'd0, d_drop}, 32'd1);
      chk("drop34 code", d_code, 32'h2B231B1C);
      chk("drop34 trig", {28'd0, d_trig}, 32'd0);
      chk("drop34 steal", {31'd0, d_steal}, 32'd0);

      send(8'h33);
      chk_s("steal33", 4'b1111, 32'h2B233334, 4'b0010, 1'b1);
      chk("drop33 code", d_code, 32'h2B231B1C);
      idle();
      chk("steal clears", {31'd0, s_steal}, 32'd0);
      chk("drop clears", {31'd0, d_drop}, 32'd0);

      // panic clear with a coincident make byte
      @(negedge clk);
      all_off    = 1'b1;
      scan_valid = 1'b1;
      scan_code  = 8'h33;
      @(negedge clk);
      all_off    = 1'b0;
      scan_valid = 1'b0;
      chk_s("alloff", 4'b0000, 32'hF0F0F0F0, 4'b0000, 1'b0);
      chk("alloff drop-dut on", {28'd0, d_on}, 32'd0);
      chk("alloff drop-dut drop", {31'd0, d_drop}, 32'd0);

      // break of voice1 using back-to-back bytes
      send(8'h1C);
      send(8'h1B);
      drive(8'hF0);
      drive(8'h1B);
      idle();
      chk_s("break1B", 4'b0001, 32'hF0F0F01C, 4'b0000, 1'b0);
      send(8'h23);
      chk_s("refill23", 4'b0011, 32'hF0F0231C, 4'b0010, 1'b0);

      // extended make and extended break produce nothing
      drive(8'hE0);
      drive(8'h75);
      drive(8'hE0);
      drive(8'hF0);
      drive(8'h75);
      idle();
      chk_s("extended", 4'b0011, 32'hF0F0231C, 4'b0000, 1'b0);
      send(8'h2B);
      chk_s("after ext", 4'b0111, 32'hF02B231C, 4'b0100, 1'b0);

      drive(8'hF0);
      drive(8'h66);
      idle();
      chk_s("break miss", 4'b0111, 32'hF02B231C, 4'b0000, 1'b0);

      drive(8'hF0);
      drive(8'hF0);
      drive(8'h1C);
      idle();
      chk_s("F0F0 break", 4'b0110, 32'hF02B23F0, 4'b0000, 1'b0);

      // F0 then E0 enters the extended path; 23 must stay held
      drive(8'hF0);
      drive(8'hE0);
      drive(8'h23);
      idle();
      chk_s("F0E0", 4'b0110, 32'hF02B23F0, 4'b0000, 1'b0);
      send(8'h1C);
      chk_s("lowest free", 4'b0111, 32'hF02B231C, 4'b0001, 1'b0);

      drive(8'hAA);
      drive(8'hFA);
      drive(8'h80);
      drive(8'h00);
      idle();
      chk_s("ignored", 4'b0111, 32'hF02B231C, 4'b0000, 1'b0);

      // reset while a break prefix is pending
      send(8'hF0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h2B);
      chk_s("reset mid-prefix", 4'b0001, 32'hF0F0F02B, 4'b0001, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
